// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types for the PLL phase sequencer: FSM state encoding and the
// PHASESEL codes of the four EHXPLLL outputs.
package pll_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOCKWAIT = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_STEP_LO  = 3'd3,
    ST_STEP_HI  = 3'd4,
    ST_RELOCK   = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Phase-shift request channel: valid/ready plus output select, direction
// and step count.
interface pll_phase_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;

  modport master (output req_valid, output req_sel, output req_dir,
                  output req_steps, input req_ready);
  modport slave  (input req_valid, input req_sel, input req_dir,
                  input req_steps, output req_ready);
endinterface

// File: rtl/pll_phase_ctrl_lock_sync_stable.sv
// Two-flop synchroniser for PLL LOCK followed by a saturating counter that
// reports when the lock has been held for LOCK_STABLE consecutive cycles.
module lock_sync_stable #(
  parameter int LOCK_STABLE = 1024,
  parameter int CNT_W       = 16
) (
  input  logic clkin,
  input  logic resetn,
  input  logic pll_locked,
  input  logic clear,
  output logic lk,
  output logic stable
);

  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(LOCK_STABLE);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;

  // bring the asynchronous LOCK into the clkin domain
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pll_locked;
      sync2_r <= sync1_r;
    end
  end

  // count consecutive locked cycles, saturating once stable
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= ZERO;
    end else if (clear || !sync2_r) begin
      cnt_r <= ZERO;
    end else if (cnt_r != SAT_VAL) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign lk     = sync2_r;
  assign stable = (cnt_r == SAT_VAL);

endmodule

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL dynamic-phase sequencer: gates system reset on a stable lock,
// then issues timed PHASESTEP pulses per request and waits for relock.
module pll_phase_ctrl
  import pll_phase_ctrl_pkg::*;
#(
  parameter int STEP_LOW     = 4,
  parameter int STEP_GAP     = 4,
  parameter int SETUP        = 2,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int CNT_W        = 16
) (
  input  logic              clkin,
  input  logic              resetn,
  input  logic              pll_locked,
  pll_phase_ctrl_if.slave   req,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  output logic              sys_resetn
);

  localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] LO_END    = CNT_W'(STEP_LOW - 1);
  localparam logic [CNT_W-1:0] HI_END    = CNT_W'(STEP_GAP - 1);
  localparam logic [CNT_W-1:0] TO_END    = CNT_W'(LOCK_TIMEOUT - 1);

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, tcnt_r;
  logic [7:0]       steps_r;
  logic [1:0]       phasesel_r;
  logic             phasedir_r, phasestep_r, ready_r, busy_r, done_r, err_r, sys_resetn_r;
  logic             ready_s, busy_s, done_s, err_s, sys_resetn_s, phasestep_s;
  logic             lk_s, stable_s, clear_s, accept_s;

  // stable counter restarts on RELOCK entry so relock is measured afresh
  assign clear_s  = (next_state_s == ST_RELOCK) && (state_r != ST_RELOCK);
  assign accept_s = (state_r == ST_IDLE) && lk_s && req.req_valid;

  lock_sync_stable #(.LOCK_STABLE(LOCK_STABLE), .CNT_W(CNT_W)) u_lock (
    .clkin      (clkin),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .clear      (clear_s),
    .lk         (lk_s),
    .stable     (stable_s)
  );

  // state, counters, latched request and registered outputs
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_LOCKWAIT;
      cnt_r        <= ZERO;
      tcnt_r       <= ZERO;
      steps_r      <= 8'd0;
      phasesel_r   <= SEL_CLKOP;
      phasedir_r   <= 1'b1;
      phasestep_r  <= 1'b1;
      ready_r      <= 1'b0;
      busy_r       <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      sys_resetn_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= (next_state_s == state_r) ? cnt_r + ONE : ZERO;
      tcnt_r  <= (state_r == ST_RELOCK) ? tcnt_r + ONE : ZERO;
      if (accept_s) begin
        steps_r    <= req.req_steps;
        phasesel_r <= req.req_sel;
        phasedir_r <= req.req_dir;
      end else if ((state_r == ST_STEP_HI) && (cnt_r == HI_END)) begin
        steps_r <= steps_r - 8'd1;
      end
      phasestep_r  <= phasestep_s;
      ready_r      <= ready_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      err_r        <= err_s;
      sys_resetn_r <= sys_resetn_s;
    end
  end

  // next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_LOCKWAIT: next_state_s = stable_s ? ST_IDLE : ST_LOCKWAIT;
      ST_IDLE: begin
        if (!lk_s) begin
          next_state_s = ST_LOCKWAIT;
        end else if (req.req_valid) begin
          next_state_s = (req.req_steps == 8'd0) ? ST_RELOCK : ST_SETUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP:   next_state_s = (cnt_r == SETUP_END) ? ST_STEP_LO : ST_SETUP;
      ST_STEP_LO: next_state_s = (cnt_r == LO_END) ? ST_STEP_HI : ST_STEP_LO;
      ST_STEP_HI: begin
        if (cnt_r != HI_END) begin
          next_state_s = ST_STEP_HI;
        end else if (steps_r == 8'd1) begin
          next_state_s = ST_RELOCK;
        end else begin
          next_state_s = ST_STEP_LO;
        end
      end
      ST_RELOCK: begin
        if (stable_s) begin
          next_state_s = ST_DONE;
        end else if (tcnt_r == TO_END) begin
          next_state_s = ST_LOCKWAIT;
        end else begin
          next_state_s = ST_RELOCK;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_LOCKWAIT;
    endcase
  end

  // outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    ready_s      = (next_state_s == ST_IDLE);
    busy_s       = (next_state_s != ST_IDLE);
    done_s       = (next_state_s == ST_DONE);
    err_s        = (state_r == ST_RELOCK) && (next_state_s == ST_LOCKWAIT);
    sys_resetn_s = (next_state_s != ST_LOCKWAIT);
    phasestep_s  = (next_state_s != ST_STEP_LO);
  end

  assign req.req_ready  = ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign sys_resetn     = sys_resetn_r;
  assign phasestep      = phasestep_r;
  assign phasesel       = phasesel_r;
  assign phasedir       = phasedir_r;
  assign phaseloadreg   = 1'b1;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with LOCK_STABLE=8, LOCK_TIMEOUT=50.
module tb_pll_phase_ctrl;
  import pll_phase_ctrl_pkg::*;

  localparam int T_SETUP = 2;
  localparam int T_LOW   = 4;
  localparam int T_GAP   = 4;
  localparam int N_VEC   = 5;
  localparam int MON     = 70;

  typedef struct {
    logic [1:0] sel;
    logic       dir;
    logic [7:0] steps;
    int         drop_at;   // cycle after acceptance where pll_locked drops (0 = never)
    int         drop_len;  // cycles held low (0 = stays low)
    int         exp_done;  // cycle of done pulse after acceptance (0 = none)
    int         exp_err;   // cycle of err pulse and sys_resetn low (0 = none)
  } vec_t;

  logic clkin = 1'b0;
  logic resetn = 1'b1;
  logic pll_locked = 1'b0;
  logic done, err, busy, phasedir, phasestep, phaseloadreg, sys_resetn;
  logic [1:0] phasesel;
  int n_vec = 0;
  int n_bad = 0;
  vec_t vt[N_VEC];

  pll_phase_ctrl_if rq();

  pll_phase_ctrl #(
    .STEP_LOW(T_LOW), .STEP_GAP(T_GAP), .SETUP(T_SETUP),
    .LOCK_STABLE(8), .LOCK_TIMEOUT(50), .CNT_W(16)
  ) dut (
    .clkin(clkin), .resetn(resetn), .pll_locked(pll_locked), .req(rq.slave),
    .done(done), .err(err), .busy(busy), .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep), .phaseloadreg(phaseloadreg), .sys_resetn(sys_resetn)
  );

  always #5 clkin = ~clkin;

  task automatic tick;
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (rq.req_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check(name, {31'd0, rq.req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, c, k, pat_bad, done_c, done_n, err_c, err_n, rst_c, low_n;
    logic exp_low;

    vt[0] = '{SEL_CLKOS,  1'b0, 8'd3, 0,  0, 36, 0};
    vt[1] = '{SEL_CLKOP,  1'b1, 8'd0, 0,  0, 10, 0};
    vt[2] = '{SEL_CLKOS3, 1'b1, 8'd2, 0,  0, 28, 0};
    vt[3] = '{SEL_CLKOS2, 1'b0, 8'd3, 11, 3, 36, 0};
    vt[4] = '{SEL_CLKOS,  1'b1, 8'd1, 3,  0, 0,  61};

    rq.req_valid = 1'b0;
    rq.req_sel   = 2'd0;
    rq.req_dir   = 1'b0;
    rq.req_steps = 8'd0;

    // reset values while reset is asserted
    #1 resetn = 1'b0;
    #1;
    check("reset_outputs",
          {22'd0, rq.req_ready, done, err, busy, phasesel, phasedir, phasestep, phaseloadreg, sys_resetn},
          {22'd0, 10'b0_0_0_1_00_1_1_1_0});
    tick(); tick(); tick();
    resetn = 1'b1;
    tick(); tick();

    // power-up: first sampling edge + 2 sync + 8 stable cycles
    pll_locked = 1'b1;
    n = 0;
    while (sys_resetn !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("powerup_latency", n, 32'd11);
    check("powerup_ready", {31'd0, rq.req_ready}, 32'd1);

    // table-driven requests
    for (int i = 0; i < N_VEC; i++) begin
      wait_ready("ready_before_vec");
      rq.req_valid = 1'b1;
      rq.req_sel   = vt[i].sel;
      rq.req_dir   = vt[i].dir;
      rq.req_steps = vt[i].steps;
      tick();
      rq.req_valid = 1'b0;
      rq.req_sel   = ~vt[i].sel;
      rq.req_dir   = ~vt[i].dir;
      rq.req_steps = 8'hFF;
      pat_bad = 0; done_c = 0; done_n = 0; err_c = 0; err_n = 0; rst_c = 0;
      for (c = 1; c <= MON; c++) begin
        k = c - 1 - T_SETUP;
        exp_low = (k >= 0) && (k < int'(vt[i].steps) * (T_LOW + T_GAP)) &&
                  ((k % (T_LOW + T_GAP)) < T_LOW);
        if (phasestep !== ~exp_low) pat_bad++;
        if (done === 1'b1) begin
          done_n++;
          if (done_c == 0) done_c = c;
        end
        if (err === 1'b1) begin
          err_n++;
          if (err_c == 0) err_c = c;
        end
        if (sys_resetn !== 1'b1 && rst_c == 0) rst_c = c;
        if (c == 1) begin
          check("vec_phasesel", {30'd0, phasesel}, {30'd0, vt[i].sel});
          check("vec_phasedir", {31'd0, phasedir}, {31'd0, vt[i].dir});
          check("vec_ready_drop", {30'd0, rq.req_ready, busy}, 32'd1);
        end
        if (vt[i].drop_at != 0 && c == vt[i].drop_at) pll_locked = 1'b0;
        if (vt[i].drop_at != 0 && vt[i].drop_len != 0 &&
            c == vt[i].drop_at + vt[i].drop_len) pll_locked = 1'b1;
        tick();
      end
      check("vec_step_pattern", pat_bad, 32'd0);
      check("vec_done_cycle", done_c, vt[i].exp_done);
      check("vec_done_count", done_n, (vt[i].exp_done != 0) ? 32'd1 : 32'd0);
      check("vec_err_cycle", err_c, vt[i].exp_err);
      check("vec_err_count", err_n, (vt[i].exp_err != 0) ? 32'd1 : 32'd0);
      check("vec_sysrst_low", rst_c, vt[i].exp_err);
      pll_locked = 1'b1;
    end

    // lock loss and request in the same IDLE cycle: lock loss wins
    wait_ready("ready_before_lkdrop");
    pll_locked = 1'b0;
    tick(); tick();
    check("lkdrop_idle_still_ready", {31'd0, rq.req_ready}, 32'd1);
    rq.req_valid = 1'b1;
    rq.req_sel   = SEL_CLKOS2;
    rq.req_dir   = 1'b0;
    rq.req_steps = 8'd1;
    tick();
    rq.req_valid = 1'b0;
    check("lkdrop_ready", {31'd0, rq.req_ready}, 32'd0);
    check("lkdrop_sysrst", {31'd0, sys_resetn}, 32'd0);
    low_n = 0; done_n = 0;
    for (int j = 0; j < 20; j++) begin
      if (phasestep !== 1'b1) low_n++;
      if (done === 1'b1) done_n++;
      tick();
    end
    check("lkdrop_no_steps", low_n, 32'd0);
    check("lkdrop_no_done", done_n, 32'd0);
    check("lkdrop_sel_kept", {30'd0, phasesel}, {30'd0, vt[N_VEC-1].sel});
    check("lkdrop_dir_kept", {31'd0, phasedir}, {31'd0, vt[N_VEC-1].dir});
    pll_locked = 1'b1;

    // async reset in the middle of a low step
    wait_ready("ready_before_midreset");
    rq.req_valid = 1'b1;
    rq.req_sel   = SEL_CLKOS3;
    rq.req_dir   = 1'b1;
    rq.req_steps = 8'd2;
    tick();
    rq.req_valid = 1'b0;
    n = 0;
    while (phasestep !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    check("midreset_step_seen", n, 32'd2);
    tick();
    #1 resetn = 1'b0;
    #1;
    check("midreset_outputs",
          {25'd0, phasestep, busy, rq.req_ready, sys_resetn, done, phasesel},
          {25'd0, 7'b1_1_0_0_0_00});
    tick(); tick();
    resetn = 1'b1;
    done_n = 0; err_n = 0;
    for (int j = 0; j < 30; j++) begin
      if (done === 1'b1) done_n++;
      if (err === 1'b1) err_n++;
      tick();
    end
    check("midreset_no_done_err", done_n + err_n, 32'd0);
    check("midreset_recovered", {31'd0, rq.req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
